clock_time_ctrl: RTL and testbench

- Time-of-day controller for the digital clock: owns the hour/minute/second counters and sequences them between normal counting and user time-setting.
- Sits between the debounced button front-end and the 7-segment display driver.
- Counts on a one-cycle 1 Hz enable in RUN mode.
- Lets the user set hours and minutes with mode/inc/dec pulses, with automatic timeout back to RUN.

---
 rtl/clock_time_ctrl.sv | 153 +++++++++++++++
 tb/tb_clock_time_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: hour/minute/second counters, RUN/SET_HOUR/SET_MIN
// sequencing driven by debounced button pulses, blink for the edited field
// and an inactivity timeout that drops a SET state back to RUN.
module clock_time_ctrl #(
  parameter int HOUR_MAX  = 23,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] state,
  output logic       blink,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam logic [4:0] HMAX = 5'(HOUR_MAX);
  localparam logic [5:0] TMO  = 6'(TIMEOUT_S);

  state_t     cur_state;
  state_t     nxt_state;
  logic [4:0] hour_nxt;
  logic [5:0] minute_nxt;
  logic [5:0] second_nxt;
  logic [5:0] tmo_cnt;
  logic [5:0] tmo_nxt;
  logic [5:0] tmo_inc;
  logic       blink_nxt;
  logic       day_nxt;
  logic       edit;

  assign state = cur_state;

  // State and time registers; asynchronous reset returns everything to 0:00:00 RUN.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RUN;
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      tmo_cnt   <= '0;
      blink     <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      hour      <= hour_nxt;
      minute    <= minute_nxt;
      second    <= second_nxt;
      tmo_cnt   <= tmo_nxt;
      blink     <= blink_nxt;
      day_pulse <= day_nxt;
    end
  end

  // Next-state and next-time logic: counting in RUN, field edits and timeout in SET.
  always_comb begin
    nxt_state  = cur_state;
    hour_nxt   = hour;
    minute_nxt = minute;
    second_nxt = second;
    tmo_nxt    = tmo_cnt;
    blink_nxt  = blink;
    day_nxt    = 1'b0;
    edit       = inc_btn ^ dec_btn;
    tmo_inc    = tmo_cnt + 6'd1;

    case (cur_state)
      RUN: begin
        blink_nxt = 1'b0;
        // mode wins over a coincident tick; the tick is simply dropped
        if (mode_btn) begin
          nxt_state = SET_HOUR;
          tmo_nxt   = '0;
        end else if (sec_tick) begin
          if (second == 6'd59) begin
            second_nxt = '0;
            if (minute == 6'd59) begin
              minute_nxt = '0;
              if (hour == HMAX) begin
                hour_nxt = '0;
                day_nxt  = 1'b1;
              end else begin
                hour_nxt = hour + 5'd1;
              end
            end else begin
              minute_nxt = minute + 6'd1;
            end
          end else begin
            second_nxt = second + 6'd1;
          end
        end
      end

      SET_HOUR, SET_MIN: begin
        if (mode_btn) begin
          tmo_nxt   = '0;
          blink_nxt = 1'b0;
          if (cur_state == SET_HOUR) begin
            nxt_state = SET_MIN;
          end else begin
            nxt_state  = RUN;
            second_nxt = '0;
          end
        end else if (edit) begin
          // accepted edit: field shows solid immediately
          tmo_nxt   = '0;
          blink_nxt = 1'b0;
          if (cur_state == SET_HOUR) begin
            if (inc_btn) hour_nxt = (hour == HMAX) ? 5'd0 : hour + 5'd1;
            else         hour_nxt = (hour == 5'd0) ? HMAX : hour - 5'd1;
          end else begin
            if (inc_btn) minute_nxt = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
            else         minute_nxt = (minute == 6'd0) ? 6'd59 : minute - 6'd1;
          end
        end else if (inc_btn) begin
          // inc and dec together: no edit, but still counts as activity
          tmo_nxt = '0;
          if (sec_tick) blink_nxt = ~blink;
        end else if (sec_tick) begin
          if (tmo_inc == TMO) begin
            nxt_state  = RUN;
            second_nxt = '0;
            tmo_nxt    = '0;
            blink_nxt  = 1'b0;
          end else begin
            tmo_nxt   = tmo_inc;
            blink_nxt = ~blink;
          end
        end
      end

      default: begin
        nxt_state  = RUN;
        second_nxt = '0;
        tmo_nxt    = '0;
        blink_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: a seconds-of-day reference model predicts the
// outputs of every cycle; a monitor pops those predictions on the falling
// edge and compares them with the DUT.
module tb_clock_time_ctrl;

  localparam int HOUR_MAX  = 23;
  localparam int TIMEOUT_S = 30;
  localparam int DAY       = (HOUR_MAX + 1) * 3600;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] state;
  logic       blink;
  logic       day_pulse;

  clock_time_ctrl #(.HOUR_MAX(HOUR_MAX), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .sec_tick(sec_tick), .mode_btn(mode_btn),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .hour(hour), .minute(minute),
    .second(second), .state(state), .blink(blink), .day_pulse(day_pulse)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int h; int m; int s; int st; int bl; int dp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state: time as seconds of day, mode 0/1/2
  int tod = 0;
  int mst = 0;
  int tmo = 0;
  int mbl = 0;
  int mdp = 0;

  function automatic void model_reset();
    tod = 0; mst = 0; tmo = 0; mbl = 0; mdp = 0;
  endfunction

  function automatic void model_step(input bit md, input bit in, input bit de, input bit tk);
    int h, mi, s;
    mdp = 0;
    if (mst == 0) begin
      mbl = 0;
      if (md) begin
        mst = 1; tmo = 0;
      end else if (tk) begin
        tod = (tod + 1) % DAY;
        mdp = (tod == 0);
      end
    end else if (md) begin
      tmo = 0; mbl = 0;
      if (mst == 1) mst = 2;
      else begin mst = 0; tod = tod - tod % 60; end
    end else begin
      if (in || de) tmo = 0;
      if (in != de) begin
        mbl = 0;
        h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
        if (mst == 1) h = in ? (h + 1) % (HOUR_MAX + 1) : (h + HOUR_MAX) % (HOUR_MAX + 1);
        else          mi = in ? (mi + 1) % 60 : (mi + 59) % 60;
        tod = h * 3600 + mi * 60 + s;
      end else if (tk) begin
        mbl = 1 - mbl;
        if (!in) begin
          tmo++;
          if (tmo == TIMEOUT_S) begin
            mst = 0; tod = tod - tod % 60; tmo = 0; mbl = 0;
          end
        end
      end
    end
  endfunction

  task automatic step(input bit md, input bit in, input bit de, input bit tk);
    exp_t e;
    mode_btn = md; inc_btn = in; dec_btn = de; sec_tick = tk;
    model_step(md, in, de, tk);
    e.h = tod / 3600; e.m = (tod / 60) % 60; e.s = tod % 60;
    e.st = mst; e.bl = mbl; e.dp = mdp;
    sbq.push_back(e);
    @(posedge clk_div); #1;
    mode_btn = 0; inc_btn = 0; dec_btn = 0; sec_tick = 0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_div); #1;
    rst_n = 0; #1;
    chk("rst_hour", int'(hour), 0);
    chk("rst_minute", int'(minute), 0);
    chk("rst_second", int'(second), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_day_pulse", int'(day_pulse), 0);
    model_reset();
    #2 rst_n = 1;
  endtask

  // Monitor: every clock cycle the DUT presents a new registered output set.
  always @(negedge clk_div) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      if (int'(hour) != mon_e.h || int'(minute) != mon_e.m || int'(second) != mon_e.s ||
          int'(state) != mon_e.st || int'(blink) != mon_e.bl || int'(day_pulse) != mon_e.dp) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got %0d:%0d:%0d st=%0d bl=%0d dp=%0d, required %0d:%0d:%0d st=%0d bl=%0d dp=%0d",
                 $time, hour, minute, second, state, blink, day_pulse,
                 mon_e.h, mon_e.m, mon_e.s, mon_e.st, mon_e.bl, mon_e.dp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit md, in, de, tk;
    int busy;

    // power-on reset held for a few edges
    repeat (3) @(posedge clk_div);
    #1;
    chk("por_hour", int'(hour), 0);
    chk("por_state", int'(state), 0);
    chk("por_second", int'(second), 0);
    @(negedge clk_div); #1 rst_n = 1;

    // 1: 3725 ticks -> 1:02:05
    for (int i = 0; i < 3725; i++) begin
      step(0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0);
    end
    chk("t1_hour", int'(hour), 1);
    chk("t1_minute", int'(minute), 2);
    chk("t1_second", int'(second), 5);

    // 2: preload 23:59:00, run to 23:59:58, then two ticks across midnight
    do_reset();
    step(1, 0, 0, 0); step(0, 0, 1, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0); step(1, 0, 0, 0);
    chk("t2_pre_hour", int'(hour), 23);
    chk("t2_pre_minute", int'(minute), 59);
    chk("t2_pre_second", int'(second), 0);
    for (int i = 0; i < 58; i++) step(0, 0, 0, 1);
    chk("t2_58_second", int'(second), 58);
    step(0, 0, 0, 1);
    chk("t2_no_pulse_59", int'(day_pulse), 0);
    step(0, 0, 0, 1);
    chk("t2_pulse", int'(day_pulse), 1);
    chk("t2_hour", int'(hour), 0);
    chk("t2_second", int'(second), 0);
    step(0, 0, 0, 0);
    chk("t2_pulse_gone", int'(day_pulse), 0);

    // 3: mode, dec, dec, mode, inc x61, mode
    do_reset();
    step(1, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 1, 0); step(1, 0, 0, 0);
    for (int i = 0; i < 61; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("t3_hour", int'(hour), 22);
    chk("t3_minute", int'(minute), 1);
    chk("t3_second", int'(second), 0);
    chk("t3_state", int'(state), 0);

    // 4: SET_MIN at 59, inc+dec together, then inc alone
    do_reset();
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("t4_both_minute", int'(minute), 59);
    step(0, 1, 0, 0);
    chk("t4_wrap_minute", int'(minute), 0);
    chk("t4_hour", int'(hour), 0);

    // 5: timeout after 30 idle ticks in SET_HOUR
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 1; i <= TIMEOUT_S; i++) begin
      step(0, 0, 0, 1);
      if (i == 29) chk("t5_state_29", int'(state), 1);
      step(0, 0, 0, 0);
    end
    chk("t5_state", int'(state), 0);
    chk("t5_second", int'(second), 0);
    chk("t5_blink", int'(blink), 0);

    // 6: async reset mid-SET_MIN, then mode+tick together in RUN
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t6_state", int'(state), 1);
    chk("t6_second", int'(second), 3);

    // random phase: alternating busy and quiet segments
    do_reset();
    for (int seg = 0; seg < 12; seg++) begin
      busy = (seg % 2 == 0);
      for (int i = 0; i < 300; i++) begin
        tk = ($urandom_range(0, 3) == 0);
        if (busy) begin
          md = ($urandom_range(0, 24) == 0);
          in = ($urandom_range(0, 5) == 0);
          de = ($urandom_range(0, 5) == 0);
        end else begin
          md = ($urandom_range(0, 299) == 0);
          in = ($urandom_range(0, 399) == 0);
          de = 0;
        end
        step(md, in, de, tk);
      end
    end

    @(negedge clk_div); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
